fpsr_btn_debouncer: RTL and testbench

- Multi-channel push-button conditioner. It sits between the raw board buttons (BtnC, BtnU, BtnD, BtnL, BtnR) and the first_person_second_row game FSM.
- Per channel it synchronizes, debounces and emits a debounced level plus single-, multi- and continuous-clock-enable strobes.
- The game FSM consumes the SCEN strobes as Start/Ack/move inputs and never sees raw bounce.
- Top maps index 0=BtnC, 1=BtnU, 2=BtnD, 3=BtnL, 4=BtnR.

---
 rtl/fpsr_btn_debouncer_if.sv | 27 ++
 rtl/fpsr_btn_debouncer.sv | 143 ++++++++++++++
 tb/tb_fpsr_btn_debouncer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fpsr_btn_debouncer_if.sv
// Button bundle: raw pin levels in, conditioned level and strobes out.
// master drives the pins, slave is the conditioner.
interface fpsr_btn_debouncer_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] dpb;
    logic [N_BTN-1:0] scen;
    logic [N_BTN-1:0] mcen;
    logic [N_BTN-1:0] ccen;

    modport master (
        output btn_in,
        input  dpb,
        input  scen,
        input  mcen,
        input  ccen
    );

    modport slave (
        input  btn_in,
        output dpb,
        output scen,
        output mcen,
        output ccen
    );
endinterface

// File: rtl/fpsr_btn_debouncer.sv
// Multi-channel push-button conditioner: 2-flop sync, debounce FSM,
// level plus single/multi/continuous clock-enable strobes per channel.
module fpsr_btn_debouncer #(
    parameter int N_BTN         = 5,
    parameter int N_DC          = 1000000,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 20000000,
    parameter int CNT_W         = 26
) (
    input logic                 Clk,
    input logic                 Reset,
    fpsr_btn_debouncer_if.slave bus
);
    typedef enum logic [2:0] {
        INI,
        WQ,
        SCEN_ST,
        HOLD,
        WR
    } state_t;

    localparam logic [CNT_W-1:0] DC_LAST  = CNT_W'(N_DC - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [N_BTN-1:0] meta_q, meta_d;
    logic [N_BTN-1:0] s_q, s_d;
    logic [N_BTN-1:0] dpb, scen, mcen, ccen;

    // Two-stage synchronizer input for the raw pins.
    always_comb begin
        meta_d = bus.btn_in;
        s_d    = meta_q;
    end

    // Synchronizer flops; cleared with the rest of the block.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            meta_q <= '0;
            s_q    <= '0;
        end else begin
            meta_q <= meta_d;
            s_q    <= s_d;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             phase_q, phase_d;
        logic             rep_hit;
        logic             s;
        logic             dpb_c, scen_c, mcen_c, ccen_c;

        assign s       = s_q[i];
        assign rep_hit = phase_q ? (cnt_q == PER_LAST)
                                 : (cnt_q == DLY_LAST);

        // Next-state, counter and strobe decode for this channel.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q + 1'b1;
            phase_d = phase_q;
            dpb_c   = 1'b0;
            scen_c  = 1'b0;
            mcen_c  = 1'b0;
            ccen_c  = 1'b0;
            unique case (state_q)
                INI: begin
                    cnt_d = '0;
                    if (s) state_d = WQ;
                end
                WQ: begin
                    if (!s) begin
                        state_d = INI;
                        cnt_d   = '0;
                    end else if (cnt_q == DC_LAST) begin
                        state_d = SCEN_ST;
                        cnt_d   = '0;
                    end
                end
                SCEN_ST: begin
                    dpb_c   = 1'b1;
                    scen_c  = 1'b1;
                    mcen_c  = 1'b1;
                    ccen_c  = 1'b1;
                    state_d = HOLD;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                end
                HOLD: begin
                    dpb_c  = 1'b1;
                    ccen_c = 1'b1;
                    // Release beats a coincident repeat match.
                    if (!s) begin
                        state_d = WR;
                        cnt_d   = '0;
                    end else if (rep_hit) begin
                        mcen_c  = 1'b1;
                        cnt_d   = '0;
                        phase_d = 1'b1;
                    end
                end
                WR: begin
                    dpb_c = 1'b1;
                    if (s) begin
                        cnt_d = '0;
                    end else if (cnt_q == DC_LAST) begin
                        state_d = INI;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = INI;
                    cnt_d   = '0;
                end
            endcase
        end

        // Per-channel state, counter and repeat-phase registers.
        always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
                state_q <= INI;
                cnt_q   <= '0;
                phase_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                phase_q <= phase_d;
            end
        end

        assign dpb[i]  = dpb_c;
        assign scen[i] = scen_c;
        assign mcen[i] = mcen_c;
        assign ccen[i] = ccen_c;
    end

    assign bus.dpb  = dpb;
    assign bus.scen = scen;
    assign bus.mcen = mcen;
    assign bus.ccen = ccen;
endmodule

// File: tb/tb_fpsr_btn_debouncer.sv
// Directed bench for fpsr_btn_debouncer with short debounce/repeat
// constants; expected cycle counts are worked out by hand.
module tb_fpsr_btn_debouncer;
    localparam int N_BTN = 5;

    logic Clk = 1'b0;
    logic Reset;

    fpsr_btn_debouncer_if #(.N_BTN(N_BTN)) bus ();

    fpsr_btn_debouncer #(
        .N_BTN(N_BTN),
        .N_DC(8),
        .REPEAT_DELAY(20),
        .REPEAT_PERIOD(10),
        .CNT_W(8)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int t_sc, n_sc, act, gap, nm;
        int mt[8];
        logic [N_BTN-1:0] sc_val;
        logic d10, ccen3, dpb9, dpb11;
        logic [N_BTN-1:0] pat;

        // Reset held with every button pressed.
        Reset      = 1'b0;
        bus.btn_in = '1;
        repeat (3) tick();
        check("rst_dpb", bus.dpb, 0);
        check("rst_scen", bus.scen, 0);
        check("rst_mcen", bus.mcen, 0);
        check("rst_ccen", bus.ccen, 0);

        Reset  = 1'b1;
        t_sc   = -1;
        n_sc   = 0;
        sc_val = '0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (bus.scen != 0) begin
                n_sc++;
                if (t_sc < 0) begin
                    t_sc   = c;
                    sc_val = bus.scen;
                end
            end
        end
        check("all_scen_lat", t_sc, 11);
        check("all_scen_val", sc_val, 5'h1f);
        check("all_scen_once", n_sc, 1);
        check("all_dpb_hold", bus.dpb, 5'h1f);
        check("all_ccen_hold", bus.ccen, 5'h1f);
        bus.btn_in = '0;
        repeat (14) tick();
        check("all_dpb_rel", bus.dpb, 0);
        check("all_ccen_rel", bus.ccen, 0);

        // Short press on channel 0: no activity at all.
        act = 0;
        bus.btn_in[0] = 1'b1;
        for (int c = 0; c < 27; c++) begin
            if (c == 7) bus.btn_in[0] = 1'b0;
            tick();
            act |= int'(bus.dpb[0] | bus.scen[0] |
                        bus.mcen[0] | bus.ccen[0]);
        end
        check("short_press", act, 0);

        // Bouncing press on channel 0, then held.
        n_sc = 0;
        for (int c = 0; c < 30; c++) begin
            bus.btn_in[0] = ((c / 3) % 2) == 0;
            tick();
            if (bus.scen[0]) n_sc++;
        end
        bus.btn_in[0] = 1'b1;
        t_sc = -1;
        d10  = 1'bx;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 10) d10 = bus.dpb[0];
            if (bus.scen[0]) begin
                n_sc++;
                if (t_sc < 0) t_sc = c;
            end
        end
        check("bnc_scen_lat", t_sc, 11);
        check("bnc_scen_once", n_sc, 1);
        check("bnc_dpb_early", d10, 0);
        check("bnc_dpb_set", bus.dpb[0], 1);
        bus.btn_in[0] = 1'b0;
        repeat (14) tick();
        check("bnc_dpb_rel", bus.dpb[0], 0);

        // Long hold on channel 1: auto-repeat and continuous enable.
        mt   = '{default: -1};
        nm   = 0;
        gap  = 0;
        t_sc = -1;
        bus.btn_in[1] = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (bus.scen[1] && t_sc < 0) t_sc = c;
            if (bus.mcen[1] && nm < 8) begin
                mt[nm] = c;
                nm++;
            end
            if (t_sc > 0 && !bus.ccen[1]) gap++;
        end
        check("hold_scen_lat", t_sc, 11);
        check("hold_mcen_cnt", nm, 4);
        check("hold_mcen_first", mt[0], 11);
        check("hold_rep_delay",
              (mt[1] - mt[0] == 20) || (mt[1] - mt[0] == 21), 1);
        check("hold_rep_per1", mt[2] - mt[1], 10);
        check("hold_rep_per2", mt[3] - mt[2], 10);
        check("hold_ccen_gap", gap, 0);

        // Bouncy release on channel 1.
        pat   = 5'b01010;
        n_sc  = 0;
        ccen3 = 1'bx;
        for (int r = 0; r < 5; r++) begin
            bus.btn_in[1] = pat[r];
            tick();
            if (r == 2) ccen3 = bus.ccen[1];
            if (bus.scen[1]) n_sc++;
        end
        dpb9  = 1'bx;
        dpb11 = 1'bx;
        for (int k = 2; k <= 14; k++) begin
            tick();
            if (k == 9) dpb9 = bus.dpb[1];
            if (k == 11) dpb11 = bus.dpb[1];
            if (bus.scen[1]) n_sc++;
        end
        check("rel_ccen_drop", ccen3, 0);
        check("rel_no_scen", n_sc, 0);
        check("rel_dpb_late", dpb9, 1);
        check("rel_dpb_fall", dpb11, 0);

        // Reset in the middle of a hold on channel 2.
        bus.btn_in[2] = 1'b1;
        repeat (15) tick();
        check("mid_dpb_hold", bus.dpb[2], 1);
        Reset = 1'b0;
        #1;
        check("mid_rst_dpb", bus.dpb, 0);
        check("mid_rst_ccen", bus.ccen, 0);
        check("mid_rst_strb", {bus.scen, bus.mcen}, 0);
        #2;
        Reset = 1'b1;
        t_sc  = -1;
        n_sc  = 0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (bus.scen[2]) begin
                n_sc++;
                if (t_sc < 0) t_sc = c;
            end
        end
        check("mid_scen_lat", t_sc, 11);
        check("mid_scen_once", n_sc, 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule
